// File: rtl/vc_pkg.sv
// vc_pkg: shared types for the VC arbiter.
// Holds the FSM encoding and the destination-bit helper.
package vc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT_VC0,
    ST_GRANT_VC1,
    ST_STALL
  } vc_state_e;

  localparam int CREDIT_W = 4;

  // bit of a popped word that selects D1 over D0
  function automatic int dest_idx(input int bw);
    return bw - 1;
  endfunction

endpackage

// File: rtl/vc_pipe.sv
// vc_pipe: two-stage pop-to-push pipeline.
// Ports: rd0/rd1 pops in, d0_in/d1_in fifo data, data/wr0/wr1 out, busy.
module vc_pipe
  import vc_pkg::*;
#(
  parameter int BW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd0,
  input  logic          rd1,
  input  logic [BW-1:0] d0_in,
  input  logic [BW-1:0] d1_in,
  output logic [BW-1:0] data,
  output logic          wr0,
  output logic          wr1,
  output logic          busy
);

  localparam int DB = dest_idx(BW);

  logic          v1;
  logic          sel1;
  logic [BW-1:0] word;

  // fifo read data is valid the cycle after the pop
  assign word = sel1 ? d1_in : d0_in;
  assign busy = v1 | wr0 | wr1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      sel1 <= 1'b0;
      wr0  <= 1'b0;
      wr1  <= 1'b0;
      data <= '0;
    end else begin
      v1   <= rd0 | rd1;
      sel1 <= rd1;
      wr0  <= v1 & ~word[DB];
      wr1  <= v1 & word[DB];
      if (v1) data <= word;
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted two-VC arbiter feeding two destination fifos.
// Ports: VCx_empty/VCx_data_out/Dx_almost_full in; VCx_rd, Dx_wr, D_data_in, idle out.
module vc_arbiter
  import vc_pkg::*;
#(
  parameter int BW     = 6,
  parameter int WEIGHT = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          VC0_empty,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC0_data_out,
  input  logic [BW-1:0] VC1_data_out,
  input  logic          D0_almost_full,
  input  logic          D1_almost_full,
  output logic          VC0_rd,
  output logic          VC1_rd,
  output logic          D0_wr,
  output logic          D1_wr,
  output logic [BW-1:0] D_data_in,
  output logic          idle
);

  vc_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                af;
  logic                vc1_turn;
  logic                pick0, pick1;
  logic                busy;

  assign af = D0_almost_full | D1_almost_full;

  // VC1 wins when VC0 is dry or VC0 used up its credit
  assign vc1_turn = !VC1_empty &&
    (VC0_empty || credit_q >= CREDIT_W'(WEIGHT));

  always_comb begin
    state_d  = ST_IDLE;
    pick0    = 1'b0;
    pick1    = 1'b0;
    unique case (1'b1)
      af: state_d = ST_STALL;
      (!af && vc1_turn): begin
        state_d = ST_GRANT_VC1;
        pick1   = 1'b1;
      end
      (!af && !vc1_turn && !VC0_empty): begin
        state_d = ST_GRANT_VC0;
        pick0   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (VC1_empty || pick1)
      credit_d = '0;
    else if (pick0)
      credit_d = credit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  // pops are combinational so backpressure stops them the same cycle
  assign VC0_rd = pick0 & reset_L;
  assign VC1_rd = pick1 & reset_L;
  assign idle   = (state_q == ST_IDLE) & ~busy;

  vc_pipe #(.BW(BW)) u_pipe (
    .clk   (clk),
    .rst_n (reset_L),
    .rd0   (VC0_rd),
    .rd1   (VC1_rd),
    .d0_in (VC0_data_out),
    .d1_in (VC1_data_out),
    .data  (D_data_in),
    .wr0   (D0_wr),
    .wr1   (D1_wr),
    .busy  (busy)
  );

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed bench for vc_arbiter.
// Fifo model upstream, word scoreboard downstream.
module tb_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       VC0_empty, VC1_empty;
  logic [5:0] VC0_data_out = '0;
  logic [5:0] VC1_data_out = '0;
  logic       D0_almost_full = 1'b0;
  logic       D1_almost_full = 1'b0;
  logic       VC0_rd, VC1_rd, D0_wr, D1_wr;
  logic [5:0] D_data_in;
  logic       idle;

  int errors = 0;
  int checks = 0;

  logic [5:0] mem0 [0:63];
  logic [5:0] mem1 [0:63];
  logic [5:0] exp_mem [0:255];
  int h0 = 0, t0 = 0, h1 = 0, t1 = 0;
  int ew = 0, er = 0;

  logic [13:0] p0;
  logic [13:0] p1;

  vc_arbiter #(.BW(6), .WEIGHT(4)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .VC0_empty      (VC0_empty),
    .VC1_empty      (VC1_empty),
    .VC0_data_out   (VC0_data_out),
    .VC1_data_out   (VC1_data_out),
    .D0_almost_full (D0_almost_full),
    .D1_almost_full (D1_almost_full),
    .VC0_rd         (VC0_rd),
    .VC1_rd         (VC1_rd),
    .D0_wr          (D0_wr),
    .D1_wr          (D1_wr),
    .D_data_in      (D_data_in),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  assign VC0_empty = (h0 == t0);
  assign VC1_empty = (h1 == t1);

  // upstream fifos: data valid the cycle after rd
  always @(posedge clk or negedge reset_L) begin
    if (reset_L) begin
      if (VC0_rd) begin
        VC0_data_out <= mem0[h0[5:0]];
        exp_mem[ew[7:0]] <= mem0[h0[5:0]];
        h0 <= h0 + 1;
        ew <= ew + 1;
      end else if (VC1_rd) begin
        VC1_data_out <= mem1[h1[5:0]];
        exp_mem[ew[7:0]] <= mem1[h1[5:0]];
        h1 <= h1 + 1;
        ew <= ew + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag,
                     input logic [3:0] s,
                     input logic [5:0] d);
    chk(tag, {22'd0, VC0_rd, VC1_rd, D0_wr, D1_wr, D_data_in},
        {22'd0, s, d});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(input logic [5:0] v);
    mem0[t0[5:0]] = v;
    t0++;
  endtask

  task automatic push1(input logic [5:0] v);
    mem1[t1[5:0]] = v;
    t1++;
  endtask

  // downstream scoreboard: every push must match the next popped word
  always @(negedge clk) begin
    logic [5:0] w;
    #2;
    if (!reset_L) begin
      er = ew;
    end else if (D0_wr || D1_wr) begin
      if (er == ew) begin
        chk("sb_extra", {31'd0, D0_wr | D1_wr}, 32'd0);
      end else begin
        w = exp_mem[er[7:0]];
        er++;
        chk("sb_word", {24'd0, D0_wr, D1_wr, D_data_in},
            {24'd0, ~w[5], w[5], w});
      end
    end
  end

  initial begin
    p0 = 14'b11110111101100;
    p1 = 14'b00001000010010;

    #1;
    chk("rst_idle", {31'd0, idle}, 32'd1);
    out("rst_out", 4'b0000, 6'h00);
    tick();
    tick();
    reset_L = 1'b1;

    // only VC0 loaded
    push0(6'h05); push0(6'h21); push0(6'h03);
    #1;
    out("t1_c0", 4'b1000, 6'h00);
    tick();
    out("t1_c1", 4'b1000, 6'h00);
    chk("t1_busy", {31'd0, idle}, 32'd0);
    tick();
    out("t1_c2", 4'b1010, 6'h05);
    tick();
    out("t1_c3", 4'b0001, 6'h21);
    tick();
    out("t1_c4", 4'b0010, 6'h03);
    tick();
    out("t1_c5", 4'b0000, 6'h03);
    chk("t1_idle", {31'd0, idle}, 32'd1);

    // both VCs loaded: VC0 x4, VC1 x1
    tick();
    for (int i = 0; i < 10; i++) push0(6'h10 + 6'(i));
    push1(6'h30); push1(6'h31); push1(6'h32);
    #1;
    for (int c = 0; c < 14; c++) begin
      chk($sformatf("t2_rd_c%0d", c), {30'd0, VC0_rd, VC1_rd},
          {30'd0, p0[13-c], p1[13-c]});
      tick();
    end
    repeat (4) tick();
    chk("t2_idle", {31'd0, idle}, 32'd1);

    // backpressure mid-stream
    tick();
    push0(6'h01); push0(6'h22); push0(6'h03);
    push0(6'h24); push0(6'h05); push0(6'h26);
    #1;
    out("t3_c0", 4'b1000, 6'h32);
    tick();
    out("t3_c1", 4'b1000, 6'h32);
    tick();
    D1_almost_full = 1'b1;
    #1;
    out("t3_c2", 4'b0010, 6'h01);
    tick();
    out("t3_c3", 4'b0001, 6'h22);
    tick();
    out("t3_c4", 4'b0000, 6'h22);
    chk("t3_stall_idle", {31'd0, idle}, 32'd0);
    tick();
    D1_almost_full = 1'b0;
    #1;
    out("t3_c5", 4'b1000, 6'h22);
    repeat (8) tick();
    chk("t3_idle", {31'd0, idle}, 32'd1);

    // reset with two words in flight
    tick();
    push0(6'h07); push0(6'h28); push0(6'h09); push0(6'h2A);
    #1;
    out("t4_c0", 4'b1000, 6'h26);
    tick();
    out("t4_c1", 4'b1000, 6'h26);
    tick();
    out("t4_c2", 4'b1010, 6'h07);
    reset_L = 1'b0;
    #1;
    out("t4_rst", 4'b0000, 6'h00);
    chk("t4_rst_idle", {31'd0, idle}, 32'd1);
    tick();
    out("t4_c3", 4'b0000, 6'h00);
    reset_L = 1'b1;
    #1;
    out("t4_rel", 4'b1000, 6'h00);
    tick();
    out("t4_c4", 4'b1000, 6'h00);
    tick();
    out("t4_c5", 4'b0010, 6'h09);
    tick();
    out("t4_c6", 4'b0001, 6'h2A);
    tick();
    out("t4_c7", 4'b0000, 6'h2A);

    // VC1 only, single word
    tick();
    push1(6'h3F);
    #1;
    out("t5_c0", 4'b0100, 6'h2A);
    tick();
    out("t5_c1", 4'b0000, 6'h2A);
    tick();
    out("t5_c2", 4'b0001, 6'h3F);
    tick();
    out("t5_c3", 4'b0000, 6'h3F);
    chk("t5_idle", {31'd0, idle}, 32'd1);

    tick();
    chk("sb_drain", er, ew);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter BW, default 6, word width of VC and destination data.
REQ-002 Parameter WEIGHT, default 4, maximum consecutive VC0 grants while VC1 is waiting (range 1..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_L  input  1  reset, asynchronous, active-low.
REQ-005 VC0_empty, VC1_empty  input  1 each  upstream VC FIFO empty flags.
REQ-006 VC0_data_out, VC1_data_out  input  BW each  upstream FIFO read data, valid the cycle after the matching rd.
REQ-007 D0_almost_full, D1_almost_full  input  1 each  downstream FIFO almost-full flags.
REQ-008 VC0_rd, VC1_rd  output  1 each  upstream pop strobes.
REQ-009 D0_wr, D1_wr  output  1 each  downstream push strobes.
REQ-010 D_data_in  output  BW  word driven to both destination FIFOs.
REQ-011 idle  output  1  high when both VCs are empty and no word is in flight.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT_VC0, GRANT_VC1 and STALL.
REQ-013 A pop SHALL be issued only when D0_almost_full and D1_almost_full are both low; otherwise FSM SHALL be in or enter STALL with no rd asserted.
REQ-014 At most one of VC0_rd/VC1_rd SHALL be high per cycle, and never for an empty VC.
REQ-015 VC0 SHALL have priority: GRANT_VC0 while VC0 non-empty, until credit counter reaches WEIGHT with VC1 non-empty, then one GRANT_VC1 cycle.
REQ-016 Credit counter (4 bit) SHALL increment per VC0 pop, clear on any VC1 pop, and clear when VC1 is empty; it SHALL never exceed WEIGHT.
REQ-017 GRANT_VC1 SHALL pop VC1 whenever VC0 is empty, with no weight limit.
REQ-018 Both VCs empty and no backpressure -> IDLE; STALL exits to the grant state chosen by REQ-015 in the cycle almost_full clears.
REQ-019 Pipeline: rd in cycle N, upstream data sampled end of N+1, D_data_in and Dx_wr driven in cycle N+2; fixed latency 2, throughput one word/cycle.
REQ-020 Destination SHALL be bit [BW-1] of the popped word: 0 -> D0_wr, 1 -> D1_wr; exactly one wr per forwarded word, none otherwise.
REQ-021 Words popped before almost_full rises (at most 2 in flight) SHALL still be forwarded; downstream FIFOs guarantee at least 2 free entries at almost_full.
REQ-022 D_data_in SHALL hold its last value when no wr is asserted.
REQ-023 idle SHALL be high only in IDLE with both pipeline valid bits low.

Reset
REQ-024 On reset_L low: FSM -> IDLE, credit = 0, pipeline valid bits = 0, all rd/wr = 0, D_data_in = 0, idle = 1, immediately and asynchronously.
REQ-025 Words in flight at reset assertion SHALL be dropped; no wr SHALL occur in the first cycle after reset release.

Structure
REQ-026 FSM state encoding and the destination-bit index SHALL be defined in a shared package vc_pkg.
REQ-027 The block SHALL be flat except one sub-module, vc_pipe, holding the two-stage data/valid/destination pipeline.

Verification
REQ-028 Only VC0 loaded with 0x05,0x21,0x03 -> VC0_rd 3 consecutive cycles; D0_wr,D1_wr,D0_wr two cycles later with those words.
REQ-029 Both VCs loaded, WEIGHT=4 -> pop pattern VC0 x4, VC1 x1, repeating; credit never exceeds 4.
REQ-030 D1_almost_full raised mid-stream -> rd drops same cycle, 2 in-flight words still written, resumes the cycle after it clears, no loss or duplication.
REQ-031 reset_L pulsed low with 2 words in flight -> all outputs 0, idle=1 asynchronously; no wr in first post-reset cycle.
REQ-032 VC0 empty, VC1 holds 0x3F -> VC1_rd once, D1_wr with 0x3F at N+2, then IDLE with idle=1.
